// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem reads,
// buffers returned words in a prefetch FIFO and hands them to the datapath via valid/ready.
module fetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  output logic [31:0] fetch_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic          r_inflight;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_count;
  logic [31:0]   r_hold_inst;
  logic [31:0]   r_hold_pc;
  logic [31:0]   r_hold_pc4;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  logic [CW:0]   w_used;
  logic          w_nonempty;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_bits;

  assign w_used     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_nonempty = (r_count != {CW{1'b0}});
  // Credits count the outstanding response, so a push can never land on a full FIFO.
  assign imem_req   = !rst && !redirect_valid && (w_used < DEPTH_W);
  assign imem_addr  = r_fetch_pc;
  assign w_push     = r_inflight && !redirect_valid;
  assign w_pop      = w_nonempty && inst_ready && !redirect_valid;
  assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

  assign inst_valid    = w_nonempty;
  assign inst          = w_nonempty ? r_mem_inst[r_rptr]          : r_hold_inst;
  assign inst_pc       = w_nonempty ? r_mem_pc[r_rptr]            : r_hold_pc;
  assign inst_pc_plus4 = w_nonempty ? r_mem_pc[r_rptr] + 32'd4    : r_hold_pc4;
  assign fetch_count   = r_fetch_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_req_addr    <= 32'h0000_0000;
      r_inflight    <= 1'b0;
      r_wptr        <= {AW{1'b0}};
      r_rptr        <= {AW{1'b0}};
      r_count       <= {CW{1'b0}};
      r_fetch_count <= 32'h0000_0000;
      r_hold_inst   <= 32'h0000_0000;
      r_hold_pc     <= 32'h0000_0000;
      r_hold_pc4    <= 32'h0000_0000;
    end else begin
      r_inflight <= imem_req;
      // Snapshot the head every cycle so an emptied FIFO keeps showing the last word.
      if (w_nonempty) begin
        r_hold_inst <= r_mem_inst[r_rptr];
        r_hold_pc   <= r_mem_pc[r_rptr];
        r_hold_pc4  <= r_mem_pc[r_rptr] + 32'd4;
      end
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_wptr     <= {AW{1'b0}};
        r_rptr     <= {AW{1'b0}};
        r_count    <= {CW{1'b0}};
      end else begin
        if (imem_req) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_req_addr <= r_fetch_pc;
        end
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr        <= r_rptr + AW'(1);
          r_fetch_count <= r_fetch_count + 32'd1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wptr] <= imem_rdata;
      r_mem_pc[r_wptr]   <= r_req_addr;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table across reset, back-pressure,
// redirect and wrap scenarios, plus a hand sequence for an asynchronous mid-stream reset.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic [31:0] fetch_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_stage #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_pc_plus4(inst_pc_plus4), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a >> 2) ^ 32'h5A5A_0000;
  endfunction

  // Memory model: one-cycle latency, garbage when no request was made.
  always @(posedge clk) imem_rdata <= imem_req ? mdata(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    bit rs; bit rv; logic [31:0] rpc; bit rdy;
    bit req; logic [31:0] addr; bit v; logic [31:0] pc; logic [31:0] fc; bit z;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rs, bit rv, logic [31:0] rpc, bit rdy, bit req,
                              logic [31:0] addr, bit v, logic [31:0] pc, logic [31:0] fc, bit z);
    vec_t r;
    r = '{rs, rv, rpc, rdy, req, addr, v, pc, fc, z};
    tbl.push_back(r);
  endfunction

  // Reset raised between edges; outputs must clear before any edge arrives.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_pc_plus4", inst_pc_plus4, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // A: streaming from reset
    add(1,0,0,1, 1,32'h00,0,32'h0,0,1);
    add(0,0,0,1, 1,32'h04,0,32'h0,0,1);
    add(0,0,0,1, 1,32'h08,1,32'h0,0,0);
    add(0,0,0,1, 1,32'h0C,1,32'h4,1,0);
    add(0,0,0,1, 1,32'h10,1,32'h8,2,0);
    add(0,0,0,1, 1,32'h14,1,32'hC,3,0);
    // B: back-pressure fills DEPTH, then release
    add(1,0,0,0, 1,32'h00,0,32'h0,0,1);
    add(0,0,0,0, 1,32'h04,0,32'h0,0,1);
    add(0,0,0,0, 1,32'h08,1,32'h0,0,0);
    add(0,0,0,0, 1,32'h0C,1,32'h0,0,0);
    add(0,0,0,0, 0,32'h10,1,32'h0,0,0);
    add(0,0,0,0, 0,32'h10,1,32'h0,0,0);
    add(0,0,0,1, 0,32'h10,1,32'h0,0,0);
    add(0,0,0,1, 1,32'h10,1,32'h4,1,0);
    add(0,0,0,1, 1,32'h14,1,32'h8,2,0);
    add(0,0,0,1, 1,32'h18,1,32'hC,3,0);
    add(0,0,0,1, 1,32'h1C,1,32'h10,4,0);
    add(0,0,0,1, 1,32'h20,1,32'h14,5,0);
    // C: redirect with 3 entries + inflight, double redirect, wrap
    add(1,0,0,0, 1,32'h00,0,32'h0,0,1);
    add(0,0,0,0, 1,32'h04,0,32'h0,0,1);
    add(0,0,0,0, 1,32'h08,1,32'h0,0,0);
    add(0,0,0,0, 1,32'h0C,1,32'h0,0,0);
    add(0,1,32'h103,1, 0,32'h10,1,32'h0,0,0);
    add(0,0,0,1, 1,32'h100,0,32'h0,0,0);
    add(0,0,0,1, 1,32'h104,0,32'h0,0,0);
    add(0,0,0,1, 1,32'h108,1,32'h100,0,0);
    add(0,0,0,1, 1,32'h10C,1,32'h104,1,0);
    add(0,1,32'h200,1, 0,32'h110,1,32'h108,2,0);
    add(0,1,32'h300,1, 0,32'h200,0,32'h108,2,0);
    add(0,0,0,1, 1,32'h300,0,32'h108,2,0);
    add(0,0,0,1, 1,32'h304,0,32'h108,2,0);
    add(0,0,0,1, 1,32'h308,1,32'h300,2,0);
    add(0,0,0,1, 1,32'h30C,1,32'h304,3,0);
    add(0,1,32'hFFFF_FFF8,1, 0,32'h310,1,32'h308,4,0);
    add(0,0,0,1, 1,32'hFFFF_FFF8,0,32'h308,4,0);
    add(0,0,0,1, 1,32'hFFFF_FFFC,0,32'h308,4,0);
    add(0,0,0,1, 1,32'h0,1,32'hFFFF_FFF8,4,0);
    add(0,0,0,1, 1,32'h4,1,32'hFFFF_FFFC,5,0);
    add(0,0,0,1, 1,32'h8,1,32'h0,6,0);

    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      @(negedge clk);
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      inst_ready     = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("row%0d_imem_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("row%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].v});
      chk($sformatf("row%0d_inst_pc", i), inst_pc, tbl[i].z ? 32'd0 : tbl[i].pc);
      chk($sformatf("row%0d_inst", i), inst, tbl[i].z ? 32'd0 : mdata(tbl[i].pc));
      chk($sformatf("row%0d_inst_pc_plus4", i), inst_pc_plus4,
          tbl[i].z ? 32'd0 : tbl[i].pc + 32'd4);
      chk($sformatf("row%0d_fetch_count", i), fetch_count, tbl[i].fc);
    end

    // Mid-stream async reset (FIFO non-empty, response inflight), then restart at RESET_PC.
    do_reset();
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("restart%0d_imem_req", k), {31'b0, imem_req}, 32'd1);
      chk($sformatf("restart%0d_imem_addr", k), imem_addr, 32'(k * 4));
      chk($sformatf("restart%0d_inst_valid", k), {31'b0, inst_valid}, {31'b0, k >= 2});
      chk($sformatf("restart%0d_fetch_count", k), fetch_count, (k >= 2) ? 32'(k - 2) : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
